// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the memory stage: EX/MEM and MEM/WB bundles,
// result-select and access-width encodings, and the bus FSM states.
package pipeline_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic            RegWrite;
      logic [1:0]      ResultSrc;
      logic            MemWrite;
      logic [2:0]      funct3;
      logic [XLEN-1:0] ALUResult;
      logic [XLEN-1:0] WriteData;
      logic [XLEN-1:0] PCPlus4;
      logic [4:0]      Rd;
      logic [XLEN-1:0] ImmExt;
   } exmem_t;

   typedef struct packed {
      logic            RegWrite;
      logic [1:0]      ResultSrc;
      logic [XLEN-1:0] ALUResult;
      logic [XLEN-1:0] ReadData;
      logic [XLEN-1:0] PCPlus4;
      logic [4:0]      Rd;
      logic [XLEN-1:0] ImmExt;
   } memwb_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } mem_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores, byte/halfword extraction with sign/zero
// extension for loads, and detection of misaligned or illegal encodings.
module lsu_align
   import pipeline_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic            is_store,
   input  logic [XLEN-1:0] write_data,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      wstrb,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_value,
   output logic            bad
);

   logic [XLEN-1:0] rdata_shifted;

   // Bring the addressed byte/halfword down to bit 0 before extending it.
   assign rdata_shifted = rdata >> {addr_lo, 3'b000};

   always_comb begin
      wstrb      = 4'b0000;
      wdata      = write_data;
      load_value = '0;
      bad        = 1'b0;
      case (funct3)
         F3_B: begin
            wstrb      = 4'b0001 << addr_lo;
            wdata      = {4{write_data[7:0]}};
            load_value = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         end
         F3_H: begin
            wstrb      = 4'b0011 << addr_lo;
            wdata      = {2{write_data[15:0]}};
            load_value = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            bad        = addr_lo[0];
         end
         F3_W: begin
            wstrb      = 4'b1111;
            load_value = rdata;
            bad        = |addr_lo;
         end
         F3_BU: begin
            load_value = {24'b0, rdata_shifted[7:0]};
            bad        = is_store;
         end
         F3_HU: begin
            load_value = {16'b0, rdata_shifted[15:0]};
            bad        = is_store | addr_lo[0];
         end
         default: bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the data-memory valid/grant/rvalid
// handshake, stalls the pipeline while an access is outstanding.
module mem_stage
   import pipeline_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  exmem_t          inputs,
   output memwb_t          outputs,
   output logic            StallM,
   output logic            MisalignM,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_wstrb,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
);

   mem_state_t      state;
   logic            is_load, is_store, is_access, bad, legal, complete;
   logic [XLEN-1:0] load_value, read_data_q;

   assign is_load   = inputs.RegWrite & (inputs.ResultSrc == RES_MEM);
   assign is_store  = inputs.MemWrite;
   assign is_access = is_load | is_store;
   assign legal     = is_access & ~bad;

   lsu_align u_align (
      .funct3     (inputs.funct3),
      .addr_lo    (inputs.ALUResult[1:0]),
      .is_store   (is_store),
      .write_data (inputs.WriteData),
      .rdata      (mem_rdata),
      .wstrb      (mem_wstrb),
      .wdata      (mem_wdata),
      .load_value (load_value),
      .bad        (bad)
   );

   always_comb begin
      complete = 1'b0;
      case (state)
         IDLE:    complete = is_store & mem_gnt;
         REQ:     complete = is_store & mem_gnt;
         RESP:    complete = mem_rvalid;
         default: complete = 1'b0;
      endcase
   end

   // Inputs are frozen by StallM while in REQ/RESP, so the access type seen
   // there is still the one that launched the request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         read_data_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (legal && mem_gnt && is_load)
                  state <= RESP;
               else if (legal && !mem_gnt)
                  state <= REQ;
            end
            REQ: begin
               if (mem_gnt)
                  state <= is_store ? IDLE : RESP;
            end
            RESP: begin
               if (mem_rvalid) begin
                  state       <= IDLE;
                  read_data_q <= load_value;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_req   = ~reset & (((state == IDLE) & legal) | (state == REQ));
   assign mem_we    = is_store;
   assign mem_addr  = {inputs.ALUResult[XLEN-1:2], 2'b00};
   assign StallM    = ~reset & legal & ~complete;
   assign MisalignM = ~reset & is_access & bad;

   always_comb begin
      outputs           = '0;
      outputs.RegWrite  = inputs.RegWrite & ~(is_access & bad);
      outputs.ResultSrc = inputs.ResultSrc;
      outputs.ALUResult = inputs.ALUResult;
      outputs.PCPlus4   = inputs.PCPlus4;
      outputs.Rd        = inputs.Rd;
      outputs.ImmExt    = inputs.ImmExt;
      if ((state == RESP) && mem_rvalid)
         outputs.ReadData = load_value;
      else if (is_load && legal)
         outputs.ReadData = read_data_q;
      else
         outputs.ReadData = '0;
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: stores, loads, misaligned and
// illegal accesses, bus back-pressure and reset during an outstanding load.
module tb_mem_stage;
   import pipeline_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   exmem_t          inputs;
   memwb_t          outputs;
   logic            StallM, MisalignM, mem_req, mem_we;
   logic [31:0]     mem_addr, mem_wdata, mem_rdata;
   logic [3:0]      mem_wstrb;
   logic            mem_gnt, mem_rvalid;

   int checks   = 0;
   int failures = 0;

   mem_stage dut (
      .clk        (clk),
      .reset      (reset),
      .inputs     (inputs),
      .outputs    (outputs),
      .StallM     (StallM),
      .MisalignM  (MisalignM),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus just after the rising edge, then move to
   // the falling edge where outputs are sampled.
   task automatic applyStimulus(input logic rst, input logic rw, input logic [1:0] rs,
                                input logic mw, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] wd, input logic gnt, input logic rv,
                                input logic [31:0] rd);
      @(posedge clk);
      #1;
      reset            = rst;
      inputs.RegWrite  = rw;
      inputs.ResultSrc = rs;
      inputs.MemWrite  = mw;
      inputs.funct3    = f3;
      inputs.ALUResult = alu;
      inputs.WriteData = wd;
      inputs.PCPlus4   = 32'h0000_0104;
      inputs.Rd        = 5'd7;
      inputs.ImmExt    = 32'h0000_0ABC;
      mem_gnt          = gnt;
      mem_rvalid       = rv;
      mem_rdata        = rd;
      @(negedge clk);
   endtask

   task automatic applyNop(input logic rst, input logic rv, input logic [31:0] rd);
      applyStimulus(rst, 1'b0, RES_ALU, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, rv, rd);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      reset  = 1'b1;
      inputs = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      applyNop(1'b1, 1'b0, 32'h0);
      applyNop(1'b1, 1'b0, 32'h0);
      checkOutput("reset_stall", {31'b0, StallM}, 32'd0);
      checkOutput("reset_req", {31'b0, mem_req}, 32'd0);
      checkOutput("reset_misalign", {31'b0, MisalignM}, 32'd0);
      checkOutput("reset_readdata", outputs.ReadData, 32'd0);

      // sb with same-cycle grant
      applyStimulus(1'b0, 1'b0, RES_ALU, 1'b1, F3_B, 32'h1003, 32'h0000_00A5, 1'b1, 1'b0, 32'h0);
      checkOutput("sb_req", {31'b0, mem_req}, 32'd1);
      checkOutput("sb_we", {31'b0, mem_we}, 32'd1);
      checkOutput("sb_addr", mem_addr, 32'h1000);
      checkOutput("sb_wstrb", {28'b0, mem_wstrb}, 32'h8);
      checkOutput("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      checkOutput("sb_stall", {31'b0, StallM}, 32'd0);
      applyNop(1'b0, 1'b0, 32'h0);
      checkOutput("sb_after_req", {31'b0, mem_req}, 32'd0);

      // lh at 0x2002: grant cycle 0, rvalid cycle 3
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_H, 32'h2002, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("lh_c0_req", {31'b0, mem_req}, 32'd1);
      checkOutput("lh_c0_we", {31'b0, mem_we}, 32'd0);
      checkOutput("lh_c0_addr", mem_addr, 32'h2000);
      checkOutput("lh_c0_stall", {31'b0, StallM}, 32'd1);
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_H, 32'h2002, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("lh_c1_req", {31'b0, mem_req}, 32'd0);
      checkOutput("lh_c1_stall", {31'b0, StallM}, 32'd1);
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_H, 32'h2002, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("lh_c2_stall", {31'b0, StallM}, 32'd1);
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_H, 32'h2002, 32'h0, 1'b0, 1'b1, 32'h8001_1234);
      checkOutput("lh_c3_stall", {31'b0, StallM}, 32'd0);
      checkOutput("lh_readdata", outputs.ReadData, 32'hFFFF_8001);
      checkOutput("lh_regwrite", {31'b0, outputs.RegWrite}, 32'd1);
      checkOutput("lh_rd", {27'b0, outputs.Rd}, 32'd7);
      checkOutput("lh_pcplus4", outputs.PCPlus4, 32'h0000_0104);
      checkOutput("lh_immext", outputs.ImmExt, 32'h0000_0ABC);
      checkOutput("lh_aluresult", outputs.ALUResult, 32'h2002);
      checkOutput("lh_resultsrc", {30'b0, outputs.ResultSrc}, 32'd1);
      applyNop(1'b0, 1'b0, 32'h0);
      checkOutput("nonload_readdata", outputs.ReadData, 32'd0);

      // lbu and lb at 0x2001 with rdata 0x0000F000
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_BU, 32'h2001, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("lbu_c0_stall", {31'b0, StallM}, 32'd1);
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_BU, 32'h2001, 32'h0, 1'b0, 1'b1, 32'h0000_F000);
      checkOutput("lbu_readdata", outputs.ReadData, 32'h0000_00F0);
      checkOutput("lbu_c1_stall", {31'b0, StallM}, 32'd0);
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_B, 32'h2001, 32'h0, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_B, 32'h2001, 32'h0, 1'b0, 1'b1, 32'h0000_F000);
      checkOutput("lb_readdata", outputs.ReadData, 32'hFFFF_FFF0);

      // misaligned sw: no request even with grant offered
      applyStimulus(1'b0, 1'b0, RES_ALU, 1'b1, F3_W, 32'h3002, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
      checkOutput("sw_mis_req", {31'b0, mem_req}, 32'd0);
      checkOutput("sw_mis_flag", {31'b0, MisalignM}, 32'd1);
      checkOutput("sw_mis_stall", {31'b0, StallM}, 32'd0);
      applyNop(1'b0, 1'b0, 32'h0);
      checkOutput("sw_mis_pulse_end", {31'b0, MisalignM}, 32'd0);
      checkOutput("sw_mis_no_req", {31'b0, mem_req}, 32'd0);

      // misaligned lw squashes RegWrite
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_W, 32'h2003, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("lw_mis_flag", {31'b0, MisalignM}, 32'd1);
      checkOutput("lw_mis_regwrite", {31'b0, outputs.RegWrite}, 32'd0);
      checkOutput("lw_mis_req", {31'b0, mem_req}, 32'd0);

      // illegal encodings: funct3 011 load, funct3 100 store
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, 3'b011, 32'h2000, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("ill_load_flag", {31'b0, MisalignM}, 32'd1);
      checkOutput("ill_load_req", {31'b0, mem_req}, 32'd0);
      applyStimulus(1'b0, 1'b0, RES_ALU, 1'b1, F3_BU, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("ill_store_flag", {31'b0, MisalignM}, 32'd1);
      checkOutput("ill_store_req", {31'b0, mem_req}, 32'd0);

      // sh at 0x4002 with grant withheld for 4 cycles
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, RES_ALU, 1'b1, F3_H, 32'h4002, 32'h1234_BEEF, 1'b0, 1'b0, 32'h0);
         checkOutput($sformatf("sh_wait%0d_req", i), {31'b0, mem_req}, 32'd1);
         checkOutput($sformatf("sh_wait%0d_addr", i), mem_addr, 32'h4000);
         checkOutput($sformatf("sh_wait%0d_wstrb", i), {28'b0, mem_wstrb}, 32'hC);
         checkOutput($sformatf("sh_wait%0d_wdata", i), mem_wdata, 32'hBEEF_BEEF);
         checkOutput($sformatf("sh_wait%0d_stall", i), {31'b0, StallM}, 32'd1);
      end
      applyStimulus(1'b0, 1'b0, RES_ALU, 1'b1, F3_H, 32'h4002, 32'h1234_BEEF, 1'b1, 1'b0, 32'h0);
      checkOutput("sh_gnt_req", {31'b0, mem_req}, 32'd1);
      checkOutput("sh_gnt_stall", {31'b0, StallM}, 32'd0);
      applyNop(1'b0, 1'b0, 32'h0);
      checkOutput("sh_idle_req", {31'b0, mem_req}, 32'd0);
      checkOutput("sh_idle_stall", {31'b0, StallM}, 32'd0);

      // reset while a load waits in RESP, then a stray rvalid
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_W, 32'h5000, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("rst_lw_stall", {31'b0, StallM}, 32'd1);
      applyStimulus(1'b1, 1'b1, RES_MEM, 1'b0, F3_W, 32'h5000, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("rst_in_resp_stall", {31'b0, StallM}, 32'd0);
      checkOutput("rst_in_resp_req", {31'b0, mem_req}, 32'd0);
      applyNop(1'b0, 1'b0, 32'h0);
      checkOutput("rst_after_stall", {31'b0, StallM}, 32'd0);
      applyNop(1'b0, 1'b1, 32'hDEAD_BEEF);
      checkOutput("stray_rvalid_readdata", outputs.ReadData, 32'd0);
      checkOutput("stray_rvalid_stall", {31'b0, StallM}, 32'd0);
      checkOutput("stray_rvalid_req", {31'b0, mem_req}, 32'd0);

      // fresh lw proves the FSM is back in IDLE
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_W, 32'h6000, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("lw_new_req", {31'b0, mem_req}, 32'd1);
      checkOutput("lw_new_stall", {31'b0, StallM}, 32'd1);
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_W, 32'h6000, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("lw_new_req_held", {31'b0, mem_req}, 32'd1);
      applyStimulus(1'b0, 1'b1, RES_MEM, 1'b0, F3_W, 32'h6000, 32'h0, 1'b0, 1'b1, 32'h1122_3344);
      checkOutput("lw_new_readdata", outputs.ReadData, 32'h1122_3344);
      checkOutput("lw_new_stall_done", {31'b0, StallM}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
